acc_seq_ctrl: RTL and testbench
===============================

// Module: acc_seq_ctrl
// PURPOSE
//   Multi-cycle sequencer for the accumulator processor. Drives instruction fetch
//   (instruction RAM, PC incrementer, stage register), then decodes the latched opcode
//   and drives data-RAM access, ALU select, accumulator load and PC branch load.
//   Sits between the stage register (opcode/flags in) and the datapath (strobes out).
// PARAMETERS
//   OPW      4   opcode width (bits of stage-register opcode field)
//   TMO_W    4   width of data-RAM wait counter
//   TMO_MAX  15  cycles in S_MEM without data_rdy before bus error
// PORTS
//   clk            in   1    system clock, rising edge
//   reset          in   1    asynchronous, active-high reset
//   opcode         in   OPW  opcode from stage register
//   acc_zero       in   1    accumulator == 0
//   acc_neg        in   1    accumulator MSB
//   data_rdy       in   1    data RAM access complete
//   instr_ram_en   out  1    instruction RAM enable
//   instr_ram_rd   out  1    instruction RAM read enable
//   pc_inc         out  1    PC incrementer strobe (PC <= PC+1)
//   pc_load        out  1    PC load from operand field (branch taken)
//   stage_ld       out  1    stage register load strobe
//   data_ram_en    out  1    data RAM enable
//   data_ram_we    out  1    data RAM write enable (STORE)
//   alu_op         out  2    00 pass(LOAD), 01 ADD, 10 SUB, 11 AND
//   acc_ld         out  1    accumulator load strobe
//   halted         out  1    core stopped (HALT or bus error)
//   bus_err        out  1    sticky: data RAM timed out
//   illegal        out  1    one-cycle pulse: undefined opcode decoded
// BEHAVIOUR
//   One clock; reset is asynchronous and active-high. All outputs Moore (state + latched opcode).
//   Reset: state=S_RST, all outputs 0, wait counter 0, bus_err 0.
//   States / transitions:
//     S_RST    -> S_FETCH unconditionally (one idle cycle after reset release).
//     S_FETCH  instr_ram_en=instr_ram_rd=stage_ld=pc_inc=1 -> S_DECODE.
//     S_DECODE opcode sampled; flags sampled this cycle:
//       0 NOP -> S_FETCH; F HALT -> S_HALT; 6 JMP -> S_BRANCH;
//       7 JZ -> S_BRANCH if acc_zero else S_FETCH; 8 JN -> S_BRANCH if acc_neg else S_FETCH;
//       1 LOAD,2 STORE,3 ADD,4 SUB,5 AND -> S_MEM (opcode latched internally);
//       9..E -> illegal=1 in S_DECODE cycle, treated as NOP -> S_FETCH.
//     S_BRANCH pc_load=1 -> S_FETCH.
//     S_MEM    data_ram_en=1, data_ram_we=1 iff STORE; held until data_rdy=1.
//       data_rdy: STORE -> S_FETCH, else -> S_WB; counter cleared.
//       no data_rdy: counter+1; counter==TMO_MAX -> bus_err=1 -> S_HALT.
//     S_WB     acc_ld=1, alu_op per latched opcode -> S_FETCH.
//     S_HALT   halted=1, all strobes 0; exits only via reset.
//   alu_op driven 00 outside S_WB. pc_inc and pc_load never both 1.
//   Cycle counts (data_rdy same cycle): NOP/not-taken 2, JMP/taken 3, STORE 3, LOAD/ALU 4.
//   data_rdy outside S_MEM ignored. Counter saturates; no wrap.
//   Reset mid-instruction: async return to S_RST, all strobes drop immediately.
// TESTING
//   1 reset 40ns, release; opcode=0 -> S_RST 1 cyc, then FETCH/DECODE alternate; pc_inc every 2nd cycle.
//   2 opcode=3 (ADD), data_rdy high in S_MEM 3rd cycle -> data_ram_en 3 cyc, we=0, then acc_ld=1 alu_op=01 1 cyc.
//   3 opcode=7 with acc_zero=1 -> pc_load=1 one cycle after DECODE; acc_zero=0 -> no pc_load, FETCH next.
//   4 opcode=2 (STORE), data_rdy never -> after 15 S_MEM cycles bus_err=1, halted=1, strobes 0 until reset.
//   5 opcode=B -> illegal pulses 1 cycle in DECODE, next cycle FETCH; opcode=F -> halted=1 held.
//   6 assert reset during S_MEM with data_ram_en=1 -> en drops same cycle; after release S_RST then FETCH.

Source files
------------

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: multi-cycle sequencer for the accumulator processor.
// Fetches through the instruction RAM and stage register, then decodes the
// latched opcode into data-RAM, ALU, accumulator and branch strobes.
// The data-RAM wait has a timeout that raises a sticky bus error and halts.
module acc_seq_ctrl #(
    parameter int OPW     = 4,
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           acc_zero,
    input  logic           acc_neg,
    input  logic           data_rdy,
    output logic           instr_ram_en,
    output logic           instr_ram_rd,
    output logic           pc_inc,
    output logic           pc_load,
    output logic           stage_ld,
    output logic           data_ram_en,
    output logic           data_ram_we,
    output logic [1:0]     alu_op,
    output logic           acc_ld,
    output logic           halted,
    output logic           bus_err,
    output logic           illegal
);

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_BRANCH,
        S_MEM,
        S_WB,
        S_HALT
    } stateT;

    localparam logic [OPW-1:0] OP_NOP   = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_STORE = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_AND   = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_JMP   = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_JZ    = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_JN    = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(4'hF);

    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TMO_MAX - 1);
    localparam logic [TMO_W-1:0] CNT_SAT  = TMO_W'(TMO_MAX);

    stateT            state;
    stateT            nextState;
    logic [OPW-1:0]   opcLat;
    logic [OPW-1:0]   nextOpc;
    logic [TMO_W-1:0] waitCnt;
    logic [TMO_W-1:0] nextCnt;
    logic             timeout;
    logic             decodeIllegal;
    logic [1:0]       nextAlu;

    // Next-state, opcode latch, wait counter and timeout decision
    always_comb begin
        nextState     = state;
        nextOpc       = opcLat;
        nextCnt       = waitCnt;
        timeout       = 1'b0;
        decodeIllegal = 1'b0;
        case (state)
            S_RST:    nextState = S_FETCH;
            S_FETCH:  nextState = S_DECODE;
            S_DECODE: begin
                nextOpc = opcode;
                nextCnt = '0;
                case (opcode)
                    OP_NOP:   nextState = S_FETCH;
                    OP_HALT:  nextState = S_HALT;
                    OP_JMP:   nextState = S_BRANCH;
                    OP_JZ:    nextState = acc_zero ? S_BRANCH : S_FETCH;
                    OP_JN:    nextState = acc_neg ? S_BRANCH : S_FETCH;
                    OP_LOAD,
                    OP_STORE,
                    OP_ADD,
                    OP_SUB,
                    OP_AND:   nextState = S_MEM;
                    default: begin
                        decodeIllegal = 1'b1;
                        nextState     = S_FETCH;
                    end
                endcase
            end
            S_BRANCH: nextState = S_FETCH;
            S_MEM: begin
                if (data_rdy) begin
                    nextCnt   = '0;
                    nextState = (opcLat == OP_STORE) ? S_FETCH : S_WB;
                end else begin
                    if (waitCnt != CNT_SAT) begin
                        nextCnt = waitCnt + 1'b1;
                    end
                    // Leave on the cycle the counter reaches TMO_MAX
                    if (waitCnt == CNT_LAST) begin
                        timeout   = 1'b1;
                        nextState = S_HALT;
                    end
                end
            end
            S_WB:     nextState = S_FETCH;
            S_HALT:   nextState = S_HALT;
            default:  nextState = S_RST;
        endcase
    end

    // ALU select for the write-back cycle, taken from the opcode that will be latched
    always_comb begin
        nextAlu = 2'b00;
        case (nextOpc)
            OP_ADD:  nextAlu = 2'b01;
            OP_SUB:  nextAlu = 2'b10;
            OP_AND:  nextAlu = 2'b11;
            default: nextAlu = 2'b00;
        endcase
    end

    // State register with outputs registered from the state being entered,
    // so each strobe is high exactly during its state and drops on async reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_RST;
            opcLat       <= '0;
            waitCnt      <= '0;
            bus_err      <= 1'b0;
            instr_ram_en <= 1'b0;
            instr_ram_rd <= 1'b0;
            pc_inc       <= 1'b0;
            pc_load      <= 1'b0;
            stage_ld     <= 1'b0;
            data_ram_en  <= 1'b0;
            data_ram_we  <= 1'b0;
            alu_op       <= 2'b00;
            acc_ld       <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= nextState;
            opcLat       <= nextOpc;
            waitCnt      <= nextCnt;
            if (timeout) begin
                bus_err <= 1'b1;
            end
            instr_ram_en <= (nextState == S_FETCH);
            instr_ram_rd <= (nextState == S_FETCH);
            pc_inc       <= (nextState == S_FETCH);
            stage_ld     <= (nextState == S_FETCH);
            pc_load      <= (nextState == S_BRANCH);
            data_ram_en  <= (nextState == S_MEM);
            data_ram_we  <= (nextState == S_MEM) && (nextOpc == OP_STORE);
            acc_ld       <= (nextState == S_WB);
            alu_op       <= (nextState == S_WB) ? nextAlu : 2'b00;
            halted       <= (nextState == S_HALT);
        end
    end

    // Illegal pulse follows the live opcode during decode; the stage register
    // only becomes valid at the start of that cycle, so it cannot be pre-registered
    always_comb begin
        illegal = (state == S_DECODE) && decodeIllegal;
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb_acc_seq_ctrl: directed scenario bench for the accumulator sequencer.
// Each task drives one scenario and compares the packed output vector
// against hand-built per-cycle expectations.
module tb_acc_seq_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       acc_zero;
    logic       acc_neg;
    logic       data_rdy;
    logic       instr_ram_en;
    logic       instr_ram_rd;
    logic       pc_inc;
    logic       pc_load;
    logic       stage_ld;
    logic       data_ram_en;
    logic       data_ram_we;
    logic [1:0] alu_op;
    logic       acc_ld;
    logic       halted;
    logic       bus_err;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    // {instr_en, instr_rd, pc_inc, pc_load, stage_ld, dram_en, dram_we, alu[1:0], acc_ld, halted, bus_err, illegal}
    logic [12:0] obs;
    assign obs = {instr_ram_en, instr_ram_rd, pc_inc, pc_load, stage_ld, data_ram_en,
                  data_ram_we, alu_op, acc_ld, halted, bus_err, illegal};

    localparam logic [12:0] V_IDLE  = 13'b0_0_0_0_0_0_0_00_0_0_0_0;
    localparam logic [12:0] V_FETCH = 13'b1_1_1_0_1_0_0_00_0_0_0_0;
    localparam logic [12:0] V_BR    = 13'b0_0_0_1_0_0_0_00_0_0_0_0;
    localparam logic [12:0] V_MRD   = 13'b0_0_0_0_0_1_0_00_0_0_0_0;
    localparam logic [12:0] V_MWR   = 13'b0_0_0_0_0_1_1_00_0_0_0_0;
    localparam logic [12:0] V_WBLD  = 13'b0_0_0_0_0_0_0_00_1_0_0_0;
    localparam logic [12:0] V_WBADD = 13'b0_0_0_0_0_0_0_01_1_0_0_0;
    localparam logic [12:0] V_WBSUB = 13'b0_0_0_0_0_0_0_10_1_0_0_0;
    localparam logic [12:0] V_WBAND = 13'b0_0_0_0_0_0_0_11_1_0_0_0;
    localparam logic [12:0] V_HALT  = 13'b0_0_0_0_0_0_0_00_0_1_0_0;
    localparam logic [12:0] V_HERR  = 13'b0_0_0_0_0_0_0_00_0_1_1_0;
    localparam logic [12:0] V_ILL   = 13'b0_0_0_0_0_0_0_00_0_0_0_1;

    acc_seq_ctrl #(.OPW(4), .TMO_W(4), .TMO_MAX(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .acc_zero     (acc_zero),
        .acc_neg      (acc_neg),
        .data_rdy     (data_rdy),
        .instr_ram_en (instr_ram_en),
        .instr_ram_rd (instr_ram_rd),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .stage_ld     (stage_ld),
        .data_ram_en  (data_ram_en),
        .data_ram_we  (data_ram_we),
        .alu_op       (alu_op),
        .acc_ld       (acc_ld),
        .halted       (halted),
        .bus_err      (bus_err),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 40ns reset pulse; called 1ns after an edge so release stays off-edge
    task automatic doReset();
        reset = 1'b1;
        #40;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] exp [8];
        exp = '{V_FETCH, V_IDLE, V_FETCH, V_IDLE, V_FETCH, V_IDLE, V_FETCH, V_IDLE};
        reset = 1'b1; opcode = 4'h0; acc_zero = 1'b0; acc_neg = 1'b0; data_rdy = 1'b0;
        #20;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, V_IDLE);
        end
        checks++;
        #21;
        reset = 1'b0;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_srst: got %b expected %b", obs, V_IDLE);
        end
        checks++;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL nop_loop step %0d: got %b expected %b", i, obs, exp[i]);
            end
            checks++;
        end
    endtask

    task automatic test_add_wait();
        logic [12:0] exp [8];
        exp = '{V_FETCH, V_IDLE, V_MRD, V_MRD, V_MRD, V_WBADD, V_FETCH, V_IDLE};
        opcode = 4'h3; data_rdy = 1'b0;
        doReset();
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL add_wait step %0d: got %b expected %b", i, obs, exp[i]);
            end
            checks++;
            data_rdy = (i == 4);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [4];
        logic [12:0] wb  [4];
        logic [12:0] exp [4];
        ops = '{4'h1, 4'h3, 4'h4, 4'h5};
        wb  = '{V_WBLD, V_WBADD, V_WBSUB, V_WBAND};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k]; data_rdy = 1'b1;
            doReset();
            exp = '{V_FETCH, V_IDLE, V_MRD, wb[k]};
            for (int i = 0; i < 4; i++) begin
                step();
                if (obs !== exp[i]) begin
                    errors++;
                    $display("FAIL alu_op op=%h step %0d: got %b expected %b", ops[k], i, obs, exp[i]);
                end
                checks++;
            end
        end
        data_rdy = 1'b0;
    endtask

    task automatic test_store();
        logic [12:0] exp [6];
        exp = '{V_FETCH, V_IDLE, V_MWR, V_FETCH, V_IDLE, V_MWR};
        opcode = 4'h2; data_rdy = 1'b1;
        doReset();
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL store step %0d: got %b expected %b", i, obs, exp[i]);
            end
            checks++;
        end
        data_rdy = 1'b0;
    endtask

    task automatic test_branch();
        logic [12:0] exp [11];
        exp = '{V_FETCH, V_IDLE, V_BR, V_FETCH, V_IDLE, V_FETCH,
                V_IDLE, V_BR, V_FETCH, V_IDLE, V_FETCH};
        opcode = 4'h7; acc_zero = 1'b1; acc_neg = 1'b0;
        doReset();
        for (int i = 0; i < 11; i++) begin
            step();
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL branch step %0d: got %b expected %b", i, obs, exp[i]);
            end
            checks++;
            if (i == 3) acc_zero = 1'b0;
            if (i == 5) begin opcode = 4'h8; acc_neg = 1'b1; end
            if (i == 8) acc_neg = 1'b0;
        end
    endtask

    task automatic test_bus_err();
        opcode = 4'h2; data_rdy = 1'b0;
        doReset();
        for (int i = 0; i < 22; i++) begin
            logic [12:0] e;
            step();
            if (i == 0)      e = V_FETCH;
            else if (i == 1) e = V_IDLE;
            else if (i < 17) e = V_MWR;
            else             e = V_HERR;
            if (obs !== e) begin
                errors++;
                $display("FAIL bus_err step %0d: got %b expected %b", i, obs, e);
            end
            checks++;
            if (i == 18) data_rdy = 1'b1;
        end
        data_rdy = 1'b0; opcode = 4'h0;
        doReset();
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL bus_err_clear: got %b expected %b", obs, V_IDLE);
        end
        checks++;
        step();
        if (obs !== V_FETCH) begin
            errors++;
            $display("FAIL bus_err_refetch: got %b expected %b", obs, V_FETCH);
        end
        checks++;
    endtask

    task automatic test_illegal_halt();
        logic [12:0] exp [8];
        exp = '{V_FETCH, V_ILL, V_FETCH, V_IDLE, V_HALT, V_HALT, V_HALT, V_HALT};
        opcode = 4'hB;
        doReset();
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL illegal_halt step %0d: got %b expected %b", i, obs, exp[i]);
            end
            checks++;
            if (i == 2) opcode = 4'hF;
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] exp [3];
        exp = '{V_FETCH, V_IDLE, V_MRD};
        opcode = 4'h1; data_rdy = 1'b0;
        doReset();
        for (int i = 0; i < 3; i++) begin
            step();
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL reset_mid step %0d: got %b expected %b", i, obs, exp[i]);
            end
            checks++;
        end
        #2;
        reset = 1'b1;
        #1;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_mid_async: got %b expected %b", obs, V_IDLE);
        end
        checks++;
        #37;
        reset = 1'b0;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_mid_srst: got %b expected %b", obs, V_IDLE);
        end
        checks++;
        step();
        if (obs !== V_FETCH) begin
            errors++;
            $display("FAIL reset_mid_fetch: got %b expected %b", obs, V_FETCH);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_add_wait();
        test_alu_ops();
        test_store();
        test_branch();
        test_bus_err();
        test_illegal_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
